// File: rtl/vga_text_avl_writer.sv
// Avalon-MM master that feeds a character stream into the VGA text-mode VRAM.
// Handles cursor tracking, CR/LF/backspace, full-screen clear and hardware scrolling.
`timescale 1ns/1ps
module vga_text_avl_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          CTRL_ADDR  = 600,
  parameter logic [31:0] CTRL_INIT  = 32'h01FF_E000,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  input  logic [7:0]  CHAR_DATA,
  output logic        CHAR_READY,
  input  logic        CLEAR,
  output logic        BUSY,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW,
  output logic [9:0]  AVM_ADDR,
  output logic        AVM_READ,
  output logic        AVM_WRITE,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST,
  input  logic        AVM_READDATAVALID
);

  typedef enum logic [2:0] {
    S_INIT_CTRL, S_CLR, S_IDLE, S_PUT, S_SCR_RD, S_SCR_WAIT, S_SCR_WR, S_SCR_CLR
  } state_t;

  localparam int          WORDS         = ROWS * COLS / 4;
  localparam int          ROW_WORDS     = COLS / 4;
  localparam logic [9:0]  LAST_WORD     = 10'(WORDS - 1);
  localparam logic [9:0]  LAST_SCR_WORD = 10'(WORDS - ROW_WORDS - 1);
  localparam logic [9:0]  ROW_WORDS_W   = 10'(ROW_WORDS);
  localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);
  localparam logic [31:0] BLANK_WORD    = {4{BLANK_CHAR}};

  state_t      r_state, w_next;
  logic [6:0]  r_col;
  logic [4:0]  r_row;
  logic [9:0]  r_wordCnt;
  logic [7:0]  r_char;
  logic        r_noAdvance;
  logic [31:0] r_rdData;
  logic        r_armed;
  logic        w_done, w_accept, w_lastRow, w_lastCol;
  logic [11:0] w_index;

  assign w_done     = !AVM_WAITREQUEST;
  assign w_accept   = CHAR_VALID && CHAR_READY;
  assign w_lastRow  = (r_row == LAST_ROW);
  assign w_lastCol  = (r_col == LAST_COL);
  assign w_index    = ({7'd0, r_row} * 12'(COLS)) + {5'd0, r_col};
  assign CHAR_READY = (r_state == S_IDLE) && !CLEAR;
  assign BUSY       = (r_state != S_IDLE);
  assign CURSOR_COL = r_col;
  assign CURSOR_ROW = r_row;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_INIT_CTRL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT_CTRL: if (r_armed && w_done) w_next = S_CLR;
      S_CLR:       if (w_done && r_wordCnt == LAST_WORD) w_next = S_IDLE;
      S_IDLE: begin
        if (CLEAR) w_next = S_CLR;
        else if (w_accept) begin
          case (CHAR_DATA)
            8'h0A:   if (w_lastRow) w_next = S_SCR_RD;
            8'h0D:   w_next = S_IDLE;
            8'h08:   if (r_col != 7'd0) w_next = S_PUT;
            default: w_next = S_PUT;
          endcase
        end
      end
      S_PUT: begin
        if (w_done) begin
          if (!r_noAdvance && w_lastCol && w_lastRow) w_next = S_SCR_RD;
          else                                        w_next = S_IDLE;
        end
      end
      S_SCR_RD:   if (w_done) w_next = S_SCR_WAIT;
      S_SCR_WAIT: if (AVM_READDATAVALID) w_next = S_SCR_WR;
      S_SCR_WR:   if (w_done) w_next = (r_wordCnt == LAST_SCR_WORD) ? S_SCR_CLR : S_SCR_RD;
      S_SCR_CLR:  if (w_done && r_wordCnt == LAST_WORD) w_next = S_IDLE;
      default:    w_next = S_INIT_CTRL;
    endcase
  end

  // Cursor, word counter and latched glyph follow the transitions chosen above.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_col       <= '0;
      r_row       <= '0;
      r_wordCnt   <= '0;
      r_char      <= '0;
      r_noAdvance <= 1'b0;
      r_rdData    <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_INIT_CTRL: if (r_armed && w_done) r_wordCnt <= '0;
        S_CLR: begin
          if (w_done) begin
            if (r_wordCnt == LAST_WORD) begin
              r_wordCnt <= '0;
              r_col     <= '0;
              r_row     <= '0;
            end else begin
              r_wordCnt <= r_wordCnt + 10'd1;
            end
          end
        end
        S_IDLE: begin
          if (CLEAR) r_wordCnt <= '0;
          else if (w_accept) begin
            case (CHAR_DATA)
              8'h0A: begin
                r_col <= '0;
                if (w_lastRow) r_wordCnt <= '0;
                else           r_row     <= r_row + 5'd1;
              end
              8'h0D: r_col <= '0;
              8'h08: begin
                if (r_col != 7'd0) begin
                  r_col       <= r_col - 7'd1;
                  r_char      <= BLANK_CHAR;
                  r_noAdvance <= 1'b1;
                end
              end
              default: begin
                r_char      <= CHAR_DATA;
                r_noAdvance <= 1'b0;
              end
            endcase
          end
        end
        S_PUT: begin
          if (w_done && !r_noAdvance) begin
            if (w_lastCol) begin
              r_col <= '0;
              if (w_lastRow) r_wordCnt <= '0;
              else           r_row     <= r_row + 5'd1;
            end else begin
              r_col <= r_col + 7'd1;
            end
          end
        end
        S_SCR_WAIT: if (AVM_READDATAVALID) r_rdData <= AVM_READDATA;
        S_SCR_WR:   if (w_done) r_wordCnt <= r_wordCnt + 10'd1;
        S_SCR_CLR: begin
          if (w_done) r_wordCnt <= (r_wordCnt == LAST_WORD) ? 10'd0 : r_wordCnt + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // The control write waits one cycle after reset so the bus is idle on the reset edge.
  always_comb begin
    AVM_READ      = 1'b0;
    AVM_WRITE     = 1'b0;
    AVM_ADDR      = '0;
    AVM_BYTE_EN   = '0;
    AVM_WRITEDATA = '0;
    case (r_state)
      S_INIT_CTRL: begin
        if (r_armed) begin
          AVM_WRITE     = 1'b1;
          AVM_ADDR      = 10'(CTRL_ADDR);
          AVM_BYTE_EN   = 4'hF;
          AVM_WRITEDATA = CTRL_INIT;
        end
      end
      S_CLR, S_SCR_CLR: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = r_wordCnt;
        AVM_BYTE_EN   = 4'hF;
        AVM_WRITEDATA = BLANK_WORD;
      end
      S_PUT: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = w_index[11:2];
        AVM_BYTE_EN   = 4'b0001 << w_index[1:0];
        AVM_WRITEDATA = {4{r_char}};
      end
      S_SCR_RD: begin
        AVM_READ    = 1'b1;
        AVM_ADDR    = r_wordCnt + ROW_WORDS_W;
        AVM_BYTE_EN = 4'hF;
      end
      S_SCR_WR: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = r_wordCnt;
        AVM_BYTE_EN   = 4'hF;
        AVM_WRITEDATA = r_rdData;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_text_avl_writer.sv
// Bench for vga_text_avl_writer: Avalon slave with VRAM, transaction log,
// and a character-screen model that predicts every bus transaction.
`timescale 1ns/1ps
module tb_vga_text_avl_writer;

  localparam int          COLS   = 80;
  localparam int          ROWS   = 30;
  localparam int          NCH    = COLS * ROWS;
  localparam int          WORDS  = NCH / 4;
  localparam int          RWORDS = COLS / 4;
  localparam logic [31:0] BLANKW = 32'h20202020;

  typedef struct packed {
    logic        isWrite;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } txn_t;

  logic        CLK = 1'b0, RESET = 1'b1, CHAR_VALID = 1'b0, CLEAR = 1'b0;
  logic [7:0]  CHAR_DATA = '0;
  logic        AVM_WAITREQUEST = 1'b0, AVM_READDATAVALID = 1'b0;
  logic [31:0] AVM_READDATA = '0;
  logic        CHAR_READY, BUSY, AVM_READ, AVM_WRITE;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;
  logic [9:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;

  int          checks = 0, errors = 0, protoErr = 0;
  logic        stallMode = 1'b0, forceStall = 1'b0;
  logic [31:0] mem [0:1023];
  int          pendCnt = 0, slvLat;
  logic [31:0] pendData;
  txn_t        logQ[$], expQ[$];
  logic [7:0]  scr [0:NCH-1];
  int          mRow = 0, mCol = 0;

  vga_text_avl_writer dut (
    .CLK(CLK), .RESET(RESET), .CHAR_VALID(CHAR_VALID), .CHAR_DATA(CHAR_DATA),
    .CHAR_READY(CHAR_READY), .CLEAR(CLEAR), .BUSY(BUSY),
    .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW),
    .AVM_ADDR(AVM_ADDR), .AVM_READ(AVM_READ), .AVM_WRITE(AVM_WRITE),
    .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITEDATA(AVM_WRITEDATA),
    .AVM_READDATA(AVM_READDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST),
    .AVM_READDATAVALID(AVM_READDATAVALID)
  );

  always #10 CLK = ~CLK;

  always @(negedge CLK) AVM_WAITREQUEST = stallMode ? ($urandom_range(0, 2) == 0) : forceStall;

  // Slave: logs completed commands, updates VRAM, returns read data after 1..3 cycles.
  always @(posedge CLK) begin
    if (RESET) begin
      pendCnt           <= 0;
      AVM_READDATAVALID <= 1'b0;
    end else begin
      AVM_READDATAVALID <= 1'b0;
      AVM_READDATA      <= $urandom;
      if (AVM_READ && AVM_WRITE) protoErr++;
      if (pendCnt != 0) begin
        pendCnt <= pendCnt - 1;
        if (pendCnt == 1) begin
          AVM_READDATAVALID <= 1'b1;
          AVM_READDATA      <= pendData;
        end
      end
      if (AVM_WRITE && !AVM_WAITREQUEST) begin
        for (int b = 0; b < 4; b++)
          if (AVM_BYTE_EN[b]) mem[AVM_ADDR][8*b +: 8] = AVM_WRITEDATA[8*b +: 8];
        logQ.push_back(txn_t'({1'b1, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA}));
      end
      if (AVM_READ && !AVM_WAITREQUEST) begin
        if (pendCnt != 0 || AVM_READDATAVALID) protoErr++;
        logQ.push_back(txn_t'({1'b0, AVM_ADDR, 4'h0, 32'h0}));
        slvLat = stallMode ? $urandom_range(1, 3) : 1;
        if (slvLat == 1) begin
          AVM_READDATAVALID <= 1'b1;
          AVM_READDATA      <= mem[AVM_ADDR];
        end else begin
          pendCnt  <= slvLat - 1;
          pendData  = mem[AVM_ADDR];
        end
      end
    end
  end

  function automatic txn_t mkTxn(input logic w, input int a, input logic [3:0] be, input logic [31:0] d);
    return txn_t'({w, 10'(a), be, d});
  endfunction

  function automatic logic [31:0] scrWord(input int w);
    return {scr[4*w+3], scr[4*w+2], scr[4*w+1], scr[4*w]};
  endfunction

  function automatic int firstDiff();
    int n = (logQ.size() < expQ.size()) ? logQ.size() : expQ.size();
    for (int i = 0; i < n; i++) if (logQ[i] !== expQ[i]) return i;
    if (logQ.size() != expQ.size()) return n;
    return -1;
  endfunction

  function automatic string txnAt(input logic fromLog, input int i);
    txn_t t;
    if (fromLog ? (i >= logQ.size()) : (i >= expQ.size())) return "none";
    t = fromLog ? logQ[i] : expQ[i];
    return $sformatf("%s a=%0d be=%b d=%h", t.isWrite ? "WR" : "RD", t.addr, t.be, t.data);
  endfunction

  // Screen model: the display is a flat array of ROWS*COLS glyphs, four per word.
  task automatic modelRowAdvance();
    if (mRow < ROWS - 1) mRow++;
    else begin
      for (int w = 0; w < WORDS - RWORDS; w++) begin
        expQ.push_back(mkTxn(1'b0, w + RWORDS, 4'h0, 32'h0));
        expQ.push_back(mkTxn(1'b1, w, 4'hF, scrWord(w + RWORDS)));
      end
      for (int i = 0; i < NCH - COLS; i++) scr[i] = scr[i + COLS];
      for (int i = NCH - COLS; i < NCH; i++) scr[i] = 8'h20;
      for (int w = WORDS - RWORDS; w < WORDS; w++) expQ.push_back(mkTxn(1'b1, w, 4'hF, BLANKW));
    end
  endtask

  task automatic modelPut(input logic [7:0] c);
    int idx = mRow * COLS + mCol;
    expQ.push_back(mkTxn(1'b1, idx / 4, 4'(1 << (idx % 4)), {4{c}}));
    scr[idx] = c;
  endtask

  task automatic modelChar(input logic [7:0] c);
    case (c)
      8'h0A: begin mCol = 0; modelRowAdvance(); end
      8'h0D: mCol = 0;
      8'h08: if (mCol > 0) begin mCol--; modelPut(8'h20); end
      default: begin
        modelPut(c);
        mCol++;
        if (mCol == COLS) begin mCol = 0; modelRowAdvance(); end
      end
    endcase
  endtask

  task automatic modelClear();
    for (int i = 0; i < NCH; i++) scr[i] = 8'h20;
    for (int w = 0; w < WORDS; w++) expQ.push_back(mkTxn(1'b1, w, 4'hF, BLANKW));
    mRow = 0;
    mCol = 0;
  endtask

  function automatic logic [7:0] randPrintable();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255)); while (c == 8'h0A || c == 8'h0D || c == 8'h08);
    return c;
  endfunction

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    @(negedge CLK);
    while (BUSY && n < budget) begin @(negedge CLK); n++; end
    if (BUSY) begin
      checks++; errors++;
      $display("[TB] FAIL %s idle timeout: BUSY=%b after %0d cycles, required 0", name, BUSY, n);
    end
  endtask

  task automatic sendChar(input logic [7:0] c);
    int n = 0;
    @(negedge CLK);
    while (!CHAR_READY && n < 5000) begin @(negedge CLK); n++; end
    if (!CHAR_READY) begin
      checks++; errors++;
      $display("[TB] FAIL sendChar ready timeout: CHAR_READY=%b, required 1", CHAR_READY);
      return;
    end
    CHAR_VALID = 1'b1;
    CHAR_DATA  = c;
    @(posedge CLK);
    #1 CHAR_VALID = 1'b0;
    modelChar(c);
    waitIdle("sendChar", 20000);
  endtask

  task automatic test_reset();
    int bad;
    RESET = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    checks++;
    if ({AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA} !== 47'd0) begin
      errors++;
      $display("[TB] FAIL reset bus: rd=%b wr=%b be=%b a=%0d d=%h, required all 0",
               AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA);
    end
    checks++;
    if ({BUSY, CHAR_READY, CURSOR_COL, CURSOR_ROW} !== {1'b1, 1'b0, 12'd0}) begin
      errors++;
      $display("[TB] FAIL reset status: busy=%b ready=%b col=%0d row=%0d, required 1 0 0 0",
               BUSY, CHAR_READY, CURSOR_COL, CURSOR_ROW);
    end
    RESET = 1'b0;
    repeat (40) @(negedge CLK);
    #1 forceStall = 1'b1;
    @(negedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA, CHAR_READY} !== 48'd0) begin
      errors++;
      $display("[TB] FAIL mid-transaction reset: rd=%b wr=%b be=%b a=%0d d=%h ready=%b, required all 0",
               AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA, CHAR_READY);
    end
    RESET      = 1'b0;
    forceStall = 1'b0;
    logQ.delete();
    expQ.delete();
    expQ.push_back(mkTxn(1'b1, 600, 4'hF, 32'h01FF_E000));
    modelClear();
    waitIdle("init", 3000);
    bad = firstDiff();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL init log: txn %0d of %0d got {%s}, required %0d txns with {%s}",
               bad, logQ.size(), txnAt(1'b1, bad), expQ.size(), txnAt(1'b0, bad));
    end
    checks++;
    if ({BUSY, CHAR_READY, CURSOR_COL, CURSOR_ROW} !== {1'b0, 1'b1, 12'd0}) begin
      errors++;
      $display("[TB] FAIL init done: busy=%b ready=%b col=%0d row=%0d, required 0 1 0 0",
               BUSY, CHAR_READY, CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_two_chars();
    int bad;
    logQ.delete(); expQ.delete();
    sendChar(8'h41);
    sendChar(8'h42);
    bad = firstDiff();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL two_chars log: txn %0d got {%s}, required {%s}",
               bad, txnAt(1'b1, bad), txnAt(1'b0, bad));
    end
    checks++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd2, 5'd0}) begin
      errors++;
      $display("[TB] FAIL two_chars cursor: (%0d,%0d), required (2,0)", CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_row_wrap();
    int bad;
    logQ.delete(); expQ.delete();
    sendChar(8'h0D);
    for (int i = 0; i < COLS; i++) sendChar(randPrintable());
    sendChar(8'h5A);
    bad = firstDiff();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL row_wrap log: txn %0d got {%s}, required {%s}",
               bad, txnAt(1'b1, bad), txnAt(1'b0, bad));
    end
    checks++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd1, 5'd1}) begin
      errors++;
      $display("[TB] FAIL row_wrap cursor: (%0d,%0d), required (1,1)", CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_waitrequest();
    int   bad, unstable = 0, readyHigh = 0, n = 0;
    txn_t first, now;
    logQ.delete(); expQ.delete();
    @(negedge CLK);
    while (!CHAR_READY && n < 100) begin @(negedge CLK); n++; end
    CHAR_VALID = 1'b1;
    CHAR_DATA  = 8'h57;
    @(posedge CLK);
    #1;
    CHAR_VALID = 1'b0;
    forceStall = 1'b1;
    modelChar(8'h57);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      now = txn_t'({AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA});
      if (k == 0) first = now;
      if (now !== first || AVM_WRITE !== 1'b1 || AVM_READ !== 1'b0) unstable++;
      if (CHAR_READY !== 1'b0) readyHigh++;
      if (k == 2) #1 forceStall = 1'b0;
    end
    waitIdle("waitrequest", 100);
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("[TB] FAIL waitrequest hold: %0d unstable/absent write cycles, required 0", unstable);
    end
    checks++;
    if (readyHigh !== 0) begin
      errors++;
      $display("[TB] FAIL waitrequest ready: CHAR_READY high in %0d stalled cycles, required 0", readyHigh);
    end
    bad = firstDiff();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL waitrequest log: %0d txns, txn %0d got {%s}, required {%s}",
               logQ.size(), bad, txnAt(1'b1, bad), txnAt(1'b0, bad));
    end
  endtask

  task automatic test_scroll();
    int bad;
    logQ.delete(); expQ.delete();
    sendChar(8'h0D);
    for (int i = 0; i < 28; i++) sendChar(8'h0A);
    for (int i = 0; i < 5; i++) sendChar(randPrintable());
    checks++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd5, 5'd29}) begin
      errors++;
      $display("[TB] FAIL scroll setup cursor: (%0d,%0d), required (5,29)", CURSOR_COL, CURSOR_ROW);
    end
    logQ.delete(); expQ.delete();
    sendChar(8'h0A);
    bad = firstDiff();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL scroll log: %0d txns, txn %0d got {%s}, required {%s}",
               logQ.size(), bad, txnAt(1'b1, bad), txnAt(1'b0, bad));
    end
    checks++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd0, 5'd29}) begin
      errors++;
      $display("[TB] FAIL scroll cursor: (%0d,%0d), required (0,29)", CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_backspace_col0();
    logQ.delete(); expQ.delete();
    sendChar(8'h08);
    checks++;
    if (logQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL backspace_col0 bus: %0d txns, required 0", logQ.size());
    end
    checks++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd0, 5'd29}) begin
      errors++;
      $display("[TB] FAIL backspace_col0 cursor: (%0d,%0d), required (0,29)", CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_clear();
    int bad, n = 0;
    logQ.delete(); expQ.delete();
    @(negedge CLK);
    CLEAR      = 1'b1;
    CHAR_VALID = 1'b1;
    CHAR_DATA  = 8'h55;
    #1;
    checks++;
    if (CHAR_READY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear ready: CHAR_READY=%b while CLEAR, required 0", CHAR_READY);
    end
    @(posedge CLK);
    #1 CLEAR = 1'b0;
    modelClear();
    @(negedge CLK);
    while (!CHAR_READY && n < 3000) begin @(negedge CLK); n++; end
    @(posedge CLK);
    #1 CHAR_VALID = 1'b0;
    modelChar(8'h55);
    waitIdle("clear", 100);
    bad = firstDiff();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL clear log: %0d txns, txn %0d got {%s}, required {%s}",
               logQ.size(), bad, txnAt(1'b1, bad), txnAt(1'b0, bad));
    end
    checks++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd1, 5'd0}) begin
      errors++;
      $display("[TB] FAIL clear cursor: (%0d,%0d), required (1,0)", CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_backspace();
    sendChar(8'h61);
    sendChar(8'h62);
    logQ.delete(); expQ.delete();
    sendChar(8'h08);
    checks++;
    if (logQ.size() !== 1 || logQ[0] !== mkTxn(1'b1, 0, 4'b0100, BLANKW)) begin
      errors++;
      $display("[TB] FAIL backspace write: %0d txns, first {%s}, required 1 txn {WR a=0 be=0100 d=20202020}",
               logQ.size(), txnAt(1'b1, 0));
    end
    checks++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'd2, 5'd0}) begin
      errors++;
      $display("[TB] FAIL backspace cursor: (%0d,%0d), required (2,0)", CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_random();
    int bad, memBad = 0, sel;
    logQ.delete(); expQ.delete();
    stallMode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 99);
      if      (sel < 25) sendChar(8'h0A);
      else if (sel < 32) sendChar(8'h0D);
      else if (sel < 42) sendChar(8'h08);
      else               sendChar(randPrintable());
    end
    stallMode = 1'b0;
    bad = firstDiff();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL random log: %0d txns, txn %0d got {%s}, required %0d txns with {%s}",
               logQ.size(), bad, txnAt(1'b1, bad), expQ.size(), txnAt(1'b0, bad));
    end
    checks++;
    if ({CURSOR_COL, CURSOR_ROW} !== {7'(mCol), 5'(mRow)}) begin
      errors++;
      $display("[TB] FAIL random cursor: (%0d,%0d), required (%0d,%0d)", CURSOR_COL, CURSOR_ROW, mCol, mRow);
    end
    for (int w = 0; w < WORDS; w++) if (mem[w] !== scrWord(w)) memBad++;
    checks++;
    if (memBad !== 0 || mem[600] !== 32'h01FF_E000) begin
      errors++;
      $display("[TB] FAIL random vram: %0d words differ, ctrl=%h, required 0 and 01ffe000", memBad, mem[600]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < NCH; i++) scr[i] = 8'h20;
    test_reset();
    test_two_chars();
    test_row_wrap();
    test_waitrequest();
    test_scroll();
    test_backspace_col0();
    test_clear();
    test_backspace();
    test_random();
    checks++;
    if (protoErr !== 0) begin
      errors++;
      $display("[TB] FAIL bus protocol: %0d violations, required 0", protoErr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vga_text_avl_writer.md
Name: vga_text_avl_writer

Overview:
- Avalon-MM master (initiator) that drives the VGA text-mode register block: 600-word VRAM at word addresses 0–599 and the control register at word address 600.
- Accepts a byte-wide character stream and writes each glyph into VRAM at a hardware-managed cursor.
- Interprets CR/LF/backspace, scrolls the screen by copying VRAM with read/write pairs, and programs colours and clears the screen after reset.
- Sits between a character source (UART/keyboard/CPU FIFO) and the text display slave on the same 50 MHz clock.

Parameters:
- COLS, 80, characters per row (20 words per row)
- ROWS, 30, rows on screen
- CTRL_ADDR, 600, word address of the control register
- CTRL_INIT, 32'h01FF_E000, control value written after reset (white foreground, black background)
- BLANK_CHAR, 8'h20, fill glyph for clear, scroll and backspace

Ports:
- CLK  in  1  system clock; reset is synchronous and active-high
- RESET  in  1  synchronous, active-high reset
- CHAR_VALID  in  1  character offered
- CHAR_DATA  in  8  glyph code; bit7 = inverse
- CHAR_READY  out  1  writer accepts a character this cycle
- CLEAR  in  1  request a full-screen clear
- BUSY  out  1  state is not IDLE
- CURSOR_COL  out  7  current column, 0..79
- CURSOR_ROW  out  5  current row, 0..29
- AVM_ADDR  out  10  word address
- AVM_READ  out  1  read request
- AVM_WRITE  out  1  write request
- AVM_BYTE_EN  out  4  byte enables
- AVM_WRITEDATA  out  32  write data
- AVM_READDATA  in  32  read data
- AVM_WAITREQUEST  in  1  slave stall
- AVM_READDATAVALID  in  1  read data valid

Behaviour:
- Reset (any cycle, including mid-transaction): on the same edge AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA, CHAR_READY and cursor go to 0; BUSY=1; state = INIT_CTRL. Any outstanding read is abandoned.
- Bus rule: AVM_READ or AVM_WRITE, with address, byte enables and data, is held stable until a cycle with WAITREQUEST=0. That cycle completes the command.
  - Never both READ and WRITE asserted.
  - At most one read outstanding.
  - Read data is captured on the first READDATAVALID cycle after the read is accepted.
- Consecutive commands may issue back-to-back, with no idle cycle required.
- States:
  - INIT_CTRL: write CTRL_INIT to CTRL_ADDR, BE=1111 → CLR.
  - CLR: write {4{BLANK_CHAR}}, BE=1111, to words 0..599 ascending; cursor := (0,0) → IDLE.
  - IDLE: CHAR_READY = !CLEAR. CLEAR=1 → CLR, and CHAR_VALID is not accepted that cycle. A handshake (CHAR_VALID && CHAR_READY) latches CHAR_DATA; CHAR_READY is 0 from the next cycle until IDLE is re-entered.
  - PUT: index = row*80+col (12-bit). AVM_ADDR = index[11:2]; BE = one-hot on index[1:0]; WRITEDATA = latched byte replicated on all 4 lanes. Then advance the cursor.
  - SCR_RD / SCR_WAIT / SCR_WR: for w = 0..579: read w+20, write the returned data to w with BE=1111.
  - SCR_CLR: write {4{BLANK_CHAR}} to words 580..599 → IDLE.
- Character codes:
  - 0x0A: col := 0 and advance the row; no bus write.
  - 0x0D: col := 0; no bus activity; → IDLE.
  - 0x08 with col > 0: col := col-1, then PUT BLANK_CHAR at the new position.
  - 0x08 with col = 0: no-op, no wrap to the previous row.
  - All other codes (bit7 included): printable → PUT.
- Cursor advance after PUT: col+1; if col+1 = 80 then col := 0 and advance the row.
- Row advance: if row < 29, row+1 → IDLE; if row = 29, row stays 29 and the writer scrolls (→ SCR_RD).
- CLEAR outside IDLE is ignored; it is not queued.
- The control register is written only after reset; CLEAR does not rewrite it.

Test Plan:
- Reset, slave with WAITREQUEST=0 and READDATAVALID 1 cycle after read → first write addr 600, data 0x01FFE000, BE 1111. Then 600 writes to addr 0..599 with data 0x20202020. BUSY falls, CHAR_READY=1, cursor (0,0).
- Send 0x41 then 0x42 → write addr 0 BE 0001 data 0x41414141, then addr 0 BE 0010 data 0x42424242; cursor (2,0).
- Send 80 printable chars then 0x5A → 0x5A written at addr 20 BE 0001; cursor (1,1).
- WAITREQUEST held high 3 cycles on a char write → write, addr, data and BE stable for 4 cycles; exactly one write completes; CHAR_READY stays 0 throughout.
- Cursor (5,29), send 0x0A:
  - expect 580 read/write pairs, each read addr w+20 followed by a write of the returned data to addr w (read addr 20 → write addr 0 first);
  - then 20 writes of 0x20202020 to addr 580..599;
  - final cursor (0,29).
- Backspace and clear:
  - Backspace at col 0 → no bus activity.
  - Backspace at (3,0) → write addr 0, BE 0100, data 0x20202020; cursor (2,0).
  - CLEAR and CHAR_VALID together in IDLE → clear runs with no char accepted; after clear the char is accepted and written at addr 0.
